// File: rtl/mbist_controller.sv
// Top-level sequencing FSM of the MBIST engine: selects normal/load mode or self-test mode,
// and pulses done for one cycle when the address/pattern counter ends a test.
//
// state | meaning
// ------+-----------------------------------------------------------
// RESET | normal path selected, counter held in load (ld=1, NbarT=0)
// TEST  | test path selected, counter counting (ld=0, NbarT=1)
module mbist_controller (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cout,
    output logic NbarT,
    output logic ld,
    output logic done
);

    typedef enum logic {
        RESET = 1'b0,
        TEST  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;

    // cout is only meaningful while counting; start only while idle.
    always_comb begin
        state_d = RESET;
        done_d  = 1'b0;
        case (state_q)
            RESET: state_d = start ? TEST : RESET;
            TEST: begin
                state_d = cout ? RESET : TEST;
                done_d  = cout;
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign NbarT = (state_q == TEST);
    assign ld    = (state_q == RESET);
    assign done  = done_q;

endmodule

// File: tb/tb_mbist_controller.sv
// Directed bench for mbist_controller: a mode/done model checked every cycle,
// plus literal expectations after each directed step.
module tb_mbist_controller;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic cout  = 1'b0;
    logic NbarT, ld, done;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking = 1'b1;

    // model: is the engine testing, and should done be high this cycle
    bit exp_test = 1'b0;
    bit exp_done = 1'b0;

    mbist_controller dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cout  (cout),
        .NbarT (NbarT),
        .ld    (ld),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            exp_done = exp_test && cout;
            if (exp_test)
                exp_test = !cout;
            else
                exp_test = start;
        end else begin
            exp_test = 1'b0;
            exp_done = 1'b0;
        end
    end

    always @(negedge rst) begin
        exp_test = 1'b0;
        exp_done = 1'b0;
    end

    always @(negedge clk) begin
        if (checking) begin
            tests_run++;
            if ({ld, NbarT, done} !== {!exp_test, exp_test, exp_done}) begin
                tests_failed++;
                $display("FAIL cycle_model t=%0t: ld/NbarT/done actual=%b%b%b required=%b%b%b",
                         $time, ld, NbarT, done, !exp_test, exp_test, exp_done);
            end
        end
    end

    task automatic lit(input string name, input logic [2:0] req);
        tests_run++;
        if ({ld, NbarT, done} !== req) begin
            tests_failed++;
            $display("FAIL %s: ld/NbarT/done actual=%b%b%b required=%b", name, ld, NbarT, done, req);
        end
    endtask

    task automatic step(input logic s, input logic c);
        start = s;
        cout  = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk);
        #2;
        lit("reset_held", 3'b100);
        rst = 1'b1;
        step(0, 0); lit("reset_released", 3'b100);
        step(0, 1); lit("cout_ignored_in_reset", 3'b100);

        step(1, 0); lit("enter_test", 3'b010);
        step(0, 0); lit("hold_test_1", 3'b010);
        step(1, 0); lit("hold_test_start_pulse", 3'b010);
        step(0, 0); lit("hold_test_3", 3'b010);

        step(0, 1); lit("exit_test_done", 3'b101);
        step(0, 0); lit("done_one_cycle", 3'b100);
        step(0, 0); lit("idle_after_exit", 3'b100);

        step(1, 0); lit("reenter_test", 3'b010);
        step(1, 1); lit("cout_wins_over_start", 3'b101);
        step(1, 0); lit("held_start_reenters", 3'b010);
        step(0, 1); lit("exit_again", 3'b101);
        step(1, 1); lit("start_with_cout_in_reset", 3'b010);
        step(0, 0); lit("test_after_both", 3'b010);

        // asynchronous abort between clock edges with cout pending
        cout = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        lit("async_abort_immediate", 3'b100);
        @(posedge clk);
        #2;
        lit("abort_no_done", 3'b100);
        rst = 1'b1;
        step(0, 0); lit("after_abort_release", 3'b100);
        step(1, 0); lit("test_after_abort", 3'b010);
        step(0, 0);
        step(0, 1); lit("final_exit", 3'b101);
        step(0, 0); lit("final_idle", 3'b100);

        @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
